// File: rtl/fcvt_i2f_stage.sv
// rtl/fcvt_i2f_stage.sv - Two-stage int-to-float issue/writeback wrapper (FCVT.S/D.W[U])

// Combinational 32-bit integer to SP/DP converter.
// SP results are returned in the low word with the upper word zero; the stage does the boxing.
module fcvt_i2f_core (
  input  logic [31:0] data,
  input  logic        is_unsigned,
  input  logic        dp,
  input  logic [2:0]  rm,
  output logic [63:0] result
);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  logic        sign;
  logic [31:0] mag;
  logic [4:0]  msb;
  logic [30:0] frac;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [7:0]  sp_exp;
  logic [10:0] dp_exp;
  logic [30:0] sp_body;

  // Normalise the magnitude so the leading one sits just above frac, then round for SP.
  always_comb begin
    sign = ~is_unsigned & data[31];
    mag  = sign ? (~data + 32'd1) : data;
    msb  = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    // frac[30:8] is the SP mantissa, frac[7] the guard bit, frac[6:0] the sticky bits.
    frac   = 31'(mag << (5'd31 - msb));
    guard  = frac[7];
    sticky = |frac[6:0];
    case (rm)
      RM_RNE:  round_up = guard & (sticky | frac[8]);
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = sign & (guard | sticky);
      RM_RUP:  round_up = ~sign & (guard | sticky);
      RM_RMM:  round_up = guard;
      default: round_up = 1'b0;
    endcase
    sp_exp = 8'd127 + {3'b000, msb};
    dp_exp = 11'd1023 + {6'b000000, msb};
    // A mantissa carry-out correctly bumps the exponent; 2^32 never overflows SP.
    sp_body = {sp_exp, frac[30:8]} + {30'd0, round_up};
    if (mag == 32'd0) begin
      result = '0;
    end else if (dp) begin
      result = {sign, dp_exp, frac, 21'd0};
    end else begin
      result = {32'd0, sign, sp_body};
    end
  end

endmodule

// Pipeline wrapper: S1 holds the request, S2 holds the converted, boxed result.
module fcvt_i2f_stage #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [2:0]       in_rm,
  input  logic             in_dp,
  input  logic             in_unsigned,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [2:0]       frm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [4:0]       out_fflags,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       fflags_acc,
  input  logic             fflags_clr
);

  logic             s1_v_q, s1_v_d;
  logic [31:0]      s1_data_q, s1_data_d;
  logic             s1_dp_q, s1_dp_d;
  logic             s1_uns_q, s1_uns_d;
  logic [2:0]       s1_rm_q, s1_rm_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_v_q, s2_v_d;
  logic [63:0]      out_result_q, out_result_d;
  logic [4:0]       out_fflags_q, out_fflags_d;
  logic             out_illegal_q, out_illegal_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [4:0]       fflags_acc_q, fflags_acc_d;

  logic             accept;
  logic             s2_adv;
  logic             out_hs;
  logic [63:0]      conv;
  logic             s1_illegal;
  logic [31:0]      s1_mag;
  logic [4:0]       s1_msb;
  logic             s1_lost;
  logic             s1_nx;

  assign s2_adv   = s1_v_q & (~s2_v_q | out_ready);
  assign in_ready = ~s1_v_q | s2_adv;
  assign accept   = in_valid & in_ready & ~flush;
  assign out_hs   = s2_v_q & out_ready;

  assign out_valid   = s2_v_q;
  assign out_result  = out_result_q;
  assign out_fflags  = out_fflags_q;
  assign out_illegal = out_illegal_q;
  assign out_tag     = out_tag_q;
  assign fflags_acc  = fflags_acc_q;

  fcvt_i2f_core u_core (
    .data        (s1_data_q),
    .is_unsigned (s1_uns_q),
    .dp          (s1_dp_q),
    .rm          (s1_rm_q),
    .result      (conv)
  );

  // S1 next state: capture on accept with rm resolved against frm; drop on advance or flush.
  always_comb begin
    s1_data_d = s1_data_q;
    s1_dp_d   = s1_dp_q;
    s1_uns_d  = s1_uns_q;
    s1_rm_d   = s1_rm_q;
    s1_tag_d  = s1_tag_q;
    if (accept) begin
      s1_data_d = in_data;
      s1_dp_d   = in_dp;
      s1_uns_d  = in_unsigned;
      s1_rm_d   = (in_rm == 3'b111) ? frm : in_rm;
      s1_tag_d  = in_tag;
    end
    if (flush) begin
      s1_v_d = 1'b0;
    end else if (accept) begin
      s1_v_d = 1'b1;
    end else if (s2_adv) begin
      s1_v_d = 1'b0;
    end else begin
      s1_v_d = s1_v_q;
    end
  end

  // Inexact detection independent of the converter: any set bit below the top 24 significant bits.
  always_comb begin
    s1_illegal = (s1_rm_q >= 3'd5);
    s1_mag     = (~s1_uns_q & s1_data_q[31]) ? (~s1_data_q + 32'd1) : s1_data_q;
    s1_msb     = '0;
    for (int i = 0; i < 32; i++) begin
      if (s1_mag[i]) s1_msb = 5'(i);
    end
    s1_lost = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (s1_mag[i] && ((i + 24) <= int'(s1_msb))) s1_lost = 1'b1;
    end
    s1_nx = ~s1_dp_q & ~s1_illegal & s1_lost;
  end

  // S2 next state: load the converted op on advance (replacing a departing result), else hold.
  always_comb begin
    out_result_d  = out_result_q;
    out_fflags_d  = out_fflags_q;
    out_illegal_d = out_illegal_q;
    out_tag_d     = out_tag_q;
    if (s2_adv) begin
      out_illegal_d = s1_illegal;
      out_tag_d     = s1_tag_q;
      if (s1_illegal) begin
        out_result_d = '0;
        out_fflags_d = '0;
      end else begin
        out_result_d = s1_dp_q ? conv : {32'hFFFF_FFFF, conv[31:0]};
        out_fflags_d = {4'b0000, s1_nx};
      end
    end
    if (flush) begin
      s2_v_d = 1'b0;
    end else if (s2_adv) begin
      s2_v_d = 1'b1;
    end else if (out_hs) begin
      s2_v_d = 1'b0;
    end else begin
      s2_v_d = s2_v_q;
    end
  end

  // Sticky flag accumulator; a CSR clear in a handshake cycle keeps that op's flags.
  always_comb begin
    fflags_acc_d = fflags_acc_q;
    if (fflags_clr) begin
      fflags_acc_d = out_hs ? out_fflags_q : 5'd0;
    end else if (out_hs) begin
      fflags_acc_d = fflags_acc_q | out_fflags_q;
    end
  end

  // Pipeline and accumulator registers; reset drops every in-flight op at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q        <= 1'b0;
      s1_data_q     <= '0;
      s1_dp_q       <= 1'b0;
      s1_uns_q      <= 1'b0;
      s1_rm_q       <= '0;
      s1_tag_q      <= '0;
      s2_v_q        <= 1'b0;
      out_result_q  <= '0;
      out_fflags_q  <= '0;
      out_illegal_q <= 1'b0;
      out_tag_q     <= '0;
      fflags_acc_q  <= '0;
    end else begin
      s1_v_q        <= s1_v_d;
      s1_data_q     <= s1_data_d;
      s1_dp_q       <= s1_dp_d;
      s1_uns_q      <= s1_uns_d;
      s1_rm_q       <= s1_rm_d;
      s1_tag_q      <= s1_tag_d;
      s2_v_q        <= s2_v_d;
      out_result_q  <= out_result_d;
      out_fflags_q  <= out_fflags_d;
      out_illegal_q <= out_illegal_d;
      out_tag_q     <= out_tag_d;
      fflags_acc_q  <= fflags_acc_d;
    end
  end

endmodule

// File: tb/tb_fcvt_i2f_stage.sv
// tb/tb_fcvt_i2f_stage.sv - Self-checking bench for fcvt_i2f_stage
module tb_fcvt_i2f_stage;

  localparam int TAG_W = 5;
  localparam logic [2:0] RNE = 3'b000;
  localparam logic [2:0] RTZ = 3'b001;
  localparam logic [2:0] RDN = 3'b010;
  localparam logic [2:0] RUP = 3'b011;
  localparam logic [2:0] RMM = 3'b100;
  localparam logic [2:0] DYN = 3'b111;

  logic             clk, rst_n;
  logic             in_valid, in_ready, in_dp, in_unsigned;
  logic [31:0]      in_data;
  logic [2:0]       in_rm, frm;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic             flush, out_valid, out_ready, out_illegal, fflags_clr;
  logic [63:0]      out_result;
  logic [4:0]       out_fflags, fflags_acc;

  fcvt_i2f_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rm(in_rm), .in_dp(in_dp), .in_unsigned(in_unsigned),
    .in_tag(in_tag), .frm(frm), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_fflags(out_fflags),
    .out_illegal(out_illegal), .out_tag(out_tag), .fflags_acc(fflags_acc),
    .fflags_clr(fflags_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      res;
    logic [4:0]       ff;
    logic             ill;
    logic [TAG_W-1:0] tag;
    int               age;
  } op_t;

  op_t              sb[$];
  logic [4:0]       acc_m;
  int               checks, errors;
  logic             use_gold;
  logic [63:0]      gold_res;
  logic [4:0]       gold_ff;
  logic             accepted;
  logic [TAG_W-1:0] tag_ctr;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp_v);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=completion", name);
  endtask

  // Single-precision value of an integer, rounded with integer arithmetic.
  function automatic logic [31:0] sp_ref(input logic [31:0] d, input logic uns,
                                         input logic [2:0] rm, output logic nx);
    longint v, m, q, rem, half;
    int     e;
    logic   s, up;
    v  = uns ? longint'({32'd0, d}) : longint'($signed(d));
    s  = (v < 0);
    m  = s ? -v : v;
    nx = 1'b0;
    if (m == 0) return 32'd0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = m << (23 - e); rem = 0; half = 1;
    end else begin
      q = m >> (e - 23); rem = m - (q << (e - 23)); half = longint'(1) << (e - 24);
    end
    nx = (rem != 0);
    case (rm)
      RNE:     up = (rem > half) || ((rem == half) && ((q % 2) == 1));
      RDN:     up = s && (rem != 0);
      RUP:     up = !s && (rem != 0);
      RMM:     up = (rem != 0) && (rem >= half);
      default: up = 1'b0;
    endcase
    if (up) q = q + 1;
    if (q == (longint'(1) << 24)) begin q = q >> 1; e++; end
    return {s, 8'(e + 127), 23'(q)};
  endfunction

  function automatic op_t op_ref(input logic [31:0] d, input logic [2:0] rm, input logic [2:0] f,
                                 input logic dp, input logic uns, input logic [TAG_W-1:0] tag);
    op_t         o;
    logic [2:0]  rme;
    longint      v;
    real         r;
    logic        nx;
    logic [31:0] sp;
    rme   = (rm == DYN) ? f : rm;
    o.tag = tag;
    o.age = 0;
    o.ill = (rme > 3'd4);
    o.res = '0;
    o.ff  = '0;
    if (!o.ill) begin
      if (dp) begin
        v     = uns ? longint'({32'd0, d}) : longint'($signed(d));
        r     = real'(v);
        o.res = $realtobits(r);
      end else begin
        sp    = sp_ref(d, uns, rme, nx);
        o.res = {32'hFFFF_FFFF, sp};
        o.ff  = {4'b0000, nx};
      end
    end
    return o;
  endfunction

  // One clock: check outputs against the in-flight queue, then update the model for the coming edge.
  task automatic cycle();
    logic exp_valid, exp_ready, hs;
    op_t  o;
    @(negedge clk);
    exp_valid = (sb.size() > 0) && (sb[0].age >= 2);
    exp_ready = !((sb.size() == 2) && !out_ready);
    chk("out_valid", out_valid, exp_valid);
    chk("in_ready", in_ready, exp_ready);
    if (exp_valid) begin
      chk("out_result", out_result, sb[0].res);
      chk("out_fflags", out_fflags, sb[0].ff);
      chk("out_illegal", out_illegal, sb[0].ill);
      chk("out_tag", out_tag, sb[0].tag);
    end
    hs = exp_valid && out_ready;
    if (fflags_clr) acc_m = hs ? sb[0].ff : 5'd0;
    else if (hs)    acc_m = acc_m | sb[0].ff;
    if (hs) o = sb.pop_front();
    accepted = 1'b0;
    if (flush) begin
      sb.delete();
    end else if (in_valid && exp_ready && rst_n) begin
      o = op_ref(in_data, in_rm, frm, in_dp, in_unsigned, in_tag);
      if (use_gold) begin o.res = gold_res; o.ff = gold_ff; end
      sb.push_back(o);
      accepted = 1'b1;
    end
    foreach (sb[i]) sb[i].age = sb[i].age + 1;
    @(posedge clk);
    #1;
    chk("fflags_acc", fflags_acc, acc_m);
  endtask

  task automatic set_req(input logic [31:0] d, input logic [2:0] rm, input logic [2:0] f,
                         input logic dp, input logic uns);
    in_data = d; in_rm = rm; frm = f; in_dp = dp; in_unsigned = uns;
    in_tag = tag_ctr; tag_ctr = tag_ctr + 1'b1;
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] rm, input logic [2:0] f,
                      input logic dp, input logic uns, input logic [63:0] gres, input logic [4:0] gff);
    set_req(d, rm, f, dp, uns);
    in_valid = 1'b1; use_gold = 1'b1; gold_res = gres; gold_ff = gff; accepted = 1'b0;
    for (int n = 0; n < 20 && !accepted; n++) cycle();
    if (!accepted) timeout_fail("send_accept");
    in_valid = 1'b0; use_gold = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 40 && sb.size() > 0; n++) cycle();
    if (sb.size() > 0) timeout_fail("drain");
    cycle();
  endtask

  initial begin
    logic [31:0] d;
    checks = 0; errors = 0; acc_m = '0; use_gold = 1'b0; tag_ctr = '0; accepted = 1'b0;
    gold_res = '0; gold_ff = '0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_rm = '0; frm = '0; in_dp = 1'b0;
    in_unsigned = 1'b0; in_tag = '0; flush = 1'b0; out_ready = 1'b1; fflags_clr = 1'b0;

    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_fflags", out_fflags, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_fflags_acc", fflags_acc, 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // SP signed 1
    send(32'd1, RNE, 3'b000, 1'b0, 1'b0, 64'hFFFFFFFF_3F800000, 5'd0);
    drain();

    // 2^24+1 under RNE, RTZ, RUP
    send(32'h01000001, RNE, 3'b000, 1'b0, 1'b0, 64'hFFFFFFFF_4B800000, 5'd1);
    send(32'h01000001, RTZ, 3'b000, 1'b0, 1'b0, 64'hFFFFFFFF_4B800000, 5'd1);
    send(32'h01000001, RUP, 3'b000, 1'b0, 1'b0, 64'hFFFFFFFF_4B800001, 5'd1);
    drain();
    chk("acc_after_nx", fflags_acc, 5'b00001);

    // DP signed and unsigned all-ones
    send(32'hFFFFFFFF, RNE, 3'b000, 1'b1, 1'b0, 64'hBFF00000_00000000, 5'd0);
    send(32'hFFFFFFFF, RNE, 3'b000, 1'b1, 1'b1, 64'h41EFFFFF_FFE00000, 5'd0);
    drain();

    // Dynamic rounding: reserved frm traps, valid frm rounds -7 down
    send(32'd5, DYN, 3'b101, 1'b0, 1'b0, 64'd0, 5'd0);
    send(32'hFFFFFFF9, DYN, 3'b010, 1'b0, 1'b0, 64'hFFFFFFFF_C0E00000, 5'd0);
    send(32'd0, RDN, 3'b000, 1'b0, 1'b0, 64'hFFFFFFFF_00000000, 5'd0);
    send(32'h80000000, RNE, 3'b000, 1'b0, 1'b0, 64'hFFFFFFFF_CF000000, 5'd0);
    drain();

    // Backpressure: three back-to-back ops against a stalled writeback
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_req(32'h01000001, RUP, 3'b000, 1'b0, 1'b0); cycle();
    set_req(32'hFFFFFFF9, RNE, 3'b000, 1'b0, 1'b0); cycle();
    set_req(32'h7FFFFFFF, RMM, 3'b000, 1'b0, 1'b0);
    repeat (4) cycle();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    accepted  = 1'b0;
    for (int n = 0; n < 10 && !accepted; n++) cycle();
    if (!accepted) timeout_fail("bp_third_accept");
    in_valid = 1'b0;
    drain();

    // Flush with both stages full; a request offered during flush is dropped
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_req(32'd3, RNE, 3'b000, 1'b0, 1'b0); cycle();
    set_req(32'd4, RNE, 3'b000, 1'b1, 1'b0); cycle();
    cycle();
    set_req(32'd9, RNE, 3'b000, 1'b0, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    repeat (3) cycle();

    // Asynchronous reset mid-stream
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_req(32'h01000001, RNE, 3'b000, 1'b0, 1'b0); cycle();
    set_req(32'd77, RNE, 3'b000, 1'b1, 1'b0); cycle();
    set_req(32'd78, RNE, 3'b000, 1'b0, 1'b0); cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_result", out_result, 0);
    chk("arst_out_fflags", out_fflags, 0);
    chk("arst_out_tag", out_tag, 0);
    chk("arst_fflags_acc", fflags_acc, 0);
    chk("arst_in_ready", in_ready, 1);
    sb.delete();
    acc_m = '0;
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (4) cycle();

    // Clear coincident with an inexact handshake
    send(32'h01000001, RNE, 3'b000, 1'b0, 1'b0, 64'hFFFFFFFF_4B800000, 5'd1);
    out_ready = 1'b0;
    fflags_clr = 1'b1;
    for (int n = 0; n < 5 && !((sb.size() > 0) && (sb[0].age >= 2)); n++) cycle();
    fflags_clr = 1'b0;
    chk("clr_alone_acc", fflags_acc, 0);
    out_ready  = 1'b1;
    fflags_clr = 1'b1;
    cycle();
    fflags_clr = 1'b0;
    chk("clr_hs_acc", fflags_acc, 5'b00001);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 7))
        0:       d = 32'd0;
        1:       d = 32'h80000000;
        2:       d = 32'hFFFFFFFF;
        3:       d = 32'h00FFFFFF + $urandom_range(0, 3);
        4:       d = $urandom_range(0, 1000);
        5:       d = $urandom >> $urandom_range(0, 8);
        default: d = $urandom;
      endcase
      set_req(d, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 49) == 0);
      fflags_clr = ($urandom_range(0, 19) == 0);
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; fflags_clr = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
